raster_core: RTL

Parametrised successor to the computational core of the 2D GPU. It latches one shape opcode and rasterises it into a stream of (address, colour) pixel writes toward the frame-buffer writer, one pixel per accepted handshake. It supports point, filled-rectangle, Bresenham-line and full-clear modes, with screen-bounds clipping. Screen size, coordinate width and colour depth are all parametrised.

---
 rtl/raster_core_if.sv | 39 +++
 rtl/raster_core.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : raster_core_if
//  Purpose  : Command/pixel bus between a shape issuer, the raster core and
//             the frame-buffer writer.
//  Revision : 1.0 - initial release
// ============================================================================
interface raster_core_if #(
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9,
  parameter int COLOR_BITS = 16,
  parameter int ADDR_BITS  = 19,
  parameter int PAD        = 18
);
  localparam int OP_W = 4 + COLOR_BITS + 3 * (X_BITS + Y_BITS) + 1 + PAD;

  logic                  new_shape;
  logic [OP_W-1:0]       full_opcode;
  logic                  data_sent;
  logic                  data_ready;
  logic [ADDR_BITS-1:0]  address;
  logic [COLOR_BITS-1:0] color;
  logic                  frame_target;
  logic                  shape_done;
  logic                  busy;

  // Shape issuer / pixel consumer side
  modport master (
    output new_shape, full_opcode, data_sent,
    input  data_ready, address, color, frame_target, shape_done, busy
  );

  // Raster core side
  modport slave (
    input  new_shape, full_opcode, data_sent,
    output data_ready, address, color, frame_target, shape_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/raster_core.sv
`default_nettype none
// ============================================================================
//  Module   : raster_core
//  Purpose  : Latches one shape opcode and rasterises it (point, filled
//             rectangle, Bresenham line, full clear) into a clipped stream of
//             (address, colour) pixel writes, one per accepted handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module raster_core #(
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9,
  parameter int COLOR_BITS = 16,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int ADDR_BITS  = 19,
  parameter int PAD        = 18
) (
  input  logic          clk,
  input  logic          n_rst,
  raster_core_if.slave  bus
);

  localparam int OP_W      = 4 + COLOR_BITS + 3 * (X_BITS + Y_BITS) + 1 + PAD;
  localparam int XY_MAX    = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
  localparam int E_W       = XY_MAX + 2;
  localparam int OP_LSB    = OP_W - 4;
  localparam int COL_LSB   = OP_LSB - COLOR_BITS;
  localparam int X1_LSB    = COL_LSB - X_BITS;
  localparam int Y1_LSB    = X1_LSB - Y_BITS;
  localparam int X2_LSB    = Y1_LSB - X_BITS;
  localparam int Y2_LSB    = X2_LSB - Y_BITS;
  localparam int FRAME_BIT = PAD;

  localparam logic [3:0] OP_POINT = 4'd1;
  localparam logic [3:0] OP_RECT  = 4'd2;
  localparam logic [3:0] OP_LINE  = 4'd3;
  localparam logic [3:0] OP_CLEAR = 4'd4;

  localparam logic [X_BITS-1:0] X_ONE  = X_BITS'(1);
  localparam logic [Y_BITS-1:0] Y_ONE  = Y_BITS'(1);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(SCREEN_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EMIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [COLOR_BITS-1:0]   color_q, color_d;
  logic                    frame_q, frame_d;
  logic [X_BITS-1:0]       x1_q, x1_d, x2_q, x2_d;
  logic [Y_BITS-1:0]       y1_q, y1_d, y2_q, y2_d;
  logic [X_BITS-1:0]       xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_BITS-1:0]       ymin_q, ymin_d, ymax_q, ymax_d;
  logic [X_BITS-1:0]       dx_q, dx_d;
  logic [Y_BITS-1:0]       dy_q, dy_d;
  logic                    sx_q, sx_d;   // 1 = x steps downward
  logic                    sy_q, sy_d;   // 1 = y steps downward
  logic signed [E_W-1:0]   err_q, err_d;
  logic [X_BITS-1:0]       cx_q, cx_d;
  logic [Y_BITS-1:0]       cy_q, cy_d;
  logic                    shape_done_q, shape_done_d;
  logic                    busy_q, busy_d;

  // Decode-time line parameters, derived from the latched endpoints
  logic [X_BITS-1:0]     abs_dx;
  logic [Y_BITS-1:0]     abs_dy;
  logic signed [E_W-1:0] err_init;
  assign abs_dx   = (x2_q >= x1_q) ? (x2_q - x1_q) : (x1_q - x2_q);
  assign abs_dy   = (y2_q >= y1_q) ? (y2_q - y1_q) : (y1_q - y2_q);
  assign err_init = $signed({{(E_W - X_BITS){1'b0}}, abs_dx})
                  - $signed({{(E_W - Y_BITS){1'b0}}, abs_dy});

  // Bresenham step decision for the current cursor
  logic signed [E_W:0] e2, dx_e, dy_e;
  logic                step_x, step_y;
  assign e2     = {err_q, 1'b0};
  assign dx_e   = $signed({{(E_W + 1 - X_BITS){1'b0}}, dx_q});
  assign dy_e   = $signed({{(E_W + 1 - Y_BITS){1'b0}}, dy_q});
  assign step_x = (e2 > -dy_e);
  assign step_y = (e2 < dx_e);

  // Clipping and pixel acceptance for the current cursor
  logic in_bounds, emit_px, advance, last_px;
  assign in_bounds = (32'(cx_q) < 32'(SCREEN_W)) && (32'(cy_q) < 32'(SCREEN_H));
  assign emit_px   = (state_q == S_EMIT) && in_bounds;
  assign advance   = (state_q == S_EMIT) && (!in_bounds || bus.data_sent);

  // Identify the final cursor position of the shape being drawn
  always_comb begin
    last_px = 1'b1;
    case (op_q)
      OP_RECT:  last_px = (cx_q == xmax_q) && (cy_q == ymax_q);
      OP_LINE:  last_px = (cx_q == x2_q) && (cy_q == y2_q);
      OP_CLEAR: last_px = (cx_q == X_LAST) && (cy_q == Y_LAST);
      default:  last_px = 1'b1;
    endcase
  end

  // Next-state logic: command latch, decode, cursor walk and completion
  always_comb begin
    logic signed [E_W:0] err_n;
    state_d  = state_q;
    op_d     = op_q;
    color_d  = color_q;
    frame_d  = frame_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    x2_d     = x2_q;
    y2_d     = y2_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    err_d    = err_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    err_n    = {err_q[E_W-1], err_q};

    case (state_q)
      S_IDLE: begin
        if (bus.new_shape) begin
          op_d    = bus.full_opcode[OP_LSB +: 4];
          color_d = bus.full_opcode[COL_LSB +: COLOR_BITS];
          x1_d    = bus.full_opcode[X1_LSB +: X_BITS];
          y1_d    = bus.full_opcode[Y1_LSB +: Y_BITS];
          x2_d    = bus.full_opcode[X2_LSB +: X_BITS];
          y2_d    = bus.full_opcode[Y2_LSB +: Y_BITS];
          frame_d = bus.full_opcode[FRAME_BIT];
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        xmin_d = (x1_q <= x2_q) ? x1_q : x2_q;
        xmax_d = (x1_q <= x2_q) ? x2_q : x1_q;
        ymin_d = (y1_q <= y2_q) ? y1_q : y2_q;
        ymax_d = (y1_q <= y2_q) ? y2_q : y1_q;
        dx_d   = abs_dx;
        dy_d   = abs_dy;
        sx_d   = (x2_q < x1_q);
        sy_d   = (y2_q < y1_q);
        err_d  = err_init;
        case (op_q)
          OP_POINT, OP_LINE: begin
            cx_d    = x1_q;
            cy_d    = y1_q;
            state_d = S_EMIT;
          end
          OP_RECT: begin
            cx_d    = (x1_q <= x2_q) ? x1_q : x2_q;
            cy_d    = (y1_q <= y2_q) ? y1_q : y2_q;
            state_d = S_EMIT;
          end
          OP_CLEAR: begin
            cx_d    = '0;
            cy_d    = '0;
            state_d = S_EMIT;
          end
          default: state_d = S_DONE;
        endcase
      end

      S_EMIT: begin
        if (advance) begin
          if (last_px) begin
            state_d = S_DONE;
          end else begin
            case (op_q)
              OP_RECT: begin
                if (cx_q == xmax_q) begin
                  cx_d = xmin_q;
                  cy_d = cy_q + Y_ONE;
                end else begin
                  cx_d = cx_q + X_ONE;
                end
              end
              OP_LINE: begin
                if (step_x) begin
                  err_n = err_n - dy_e;
                  cx_d  = sx_q ? (cx_q - X_ONE) : (cx_q + X_ONE);
                end
                if (step_y) begin
                  err_n = err_n + dx_e;
                  cy_d  = sy_q ? (cy_q - Y_ONE) : (cy_q + Y_ONE);
                end
                err_d = err_n[E_W-1:0];
              end
              OP_CLEAR: begin
                if (cx_q == X_LAST) begin
                  cx_d = '0;
                  cy_d = cy_q + Y_ONE;
                end else begin
                  cx_d = cx_q + X_ONE;
                end
              end
              default: state_d = S_DONE;
            endcase
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    shape_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // State register; a low n_rst discards any shape in flight
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      color_q      <= '0;
      frame_q      <= 1'b0;
      x1_q         <= '0;
      y1_q         <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      sx_q         <= 1'b0;
      sy_q         <= 1'b0;
      err_q        <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      shape_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      color_q      <= color_d;
      frame_q      <= frame_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      x2_q         <= x2_d;
      y2_q         <= y2_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      err_q        <= err_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      shape_done_q <= shape_done_d;
      busy_q       <= busy_d;
    end
  end

  // Pixel address follows the registered cursor directly
  assign bus.address      = ADDR_BITS'(cy_q) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(cx_q);
  assign bus.data_ready   = emit_px;
  assign bus.color        = color_q;
  assign bus.frame_target = frame_q;
  assign bus.shape_done   = shape_done_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire
